// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_pkg
//  Description : Shared state encoding and line levels for the serial link.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_START = 2'd1;
    localparam state_t S_DATA  = 2'd2;
    localparam state_t S_STOP  = 2'd3;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bit_timer.sv
`default_nettype none
// ============================================================================
//  Module      : bit_timer
//  Description : Counts CLKS_PER_BIT clocks and pulses tick on the last one.
//  Revision    : 1.0 - initial release
// ============================================================================
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int                c_CW   = $clog2(CLKS_PER_BIT + 1);
    localparam logic [c_CW-1:0]   c_LAST = c_CW'(CLKS_PER_BIT - 1);

    logic [c_CW-1:0] r_cnt;

    assign tick = (r_cnt == c_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clear || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/serial_tx.sv
`default_nettype none
// ============================================================================
//  Module      : serial_tx
//  Description : Framed serial transmitter (start, DATA_W bits LSB first, stop).
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_tx
    import serial_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_out,
    output logic              busy,
    output logic              done
);

    localparam int              c_BW       = cnt_w(DATA_W);
    localparam logic [c_BW-1:0] c_LAST_BIT = c_BW'(DATA_W - 1);

    state_t            r_state;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] w_shift_next;
    logic [c_BW-1:0]   r_bit_cnt;
    logic              w_tick;
    logic              w_timer_clear;

    // Holding the timer cleared in IDLE makes the first START cycle count 0.
    assign w_timer_clear = (r_state == S_IDLE);
    assign w_shift_next  = r_shift >> 1;

    bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (w_timer_clear),
        .tick  (w_tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            tx_out    <= LINE_IDLE;
            tx_ready  <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (tx_valid && tx_ready) begin
                        r_shift   <= tx_data;
                        r_bit_cnt <= '0;
                        r_state   <= S_START;
                        tx_out    <= LINE_START;
                        tx_ready  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        r_state <= S_DATA;
                        tx_out  <= r_shift[0];
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        if (r_bit_cnt == c_LAST_BIT) begin
                            r_state <= S_STOP;
                            tx_out  <= LINE_IDLE;
                        end else begin
                            r_shift   <= w_shift_next;
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            tx_out    <= w_shift_next[0];
                        end
                    end
                end
                S_STOP: begin
                    if (w_tick) begin
                        r_state  <= S_IDLE;
                        tx_ready <= 1'b1;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_tx
//  Description : Scoreboard bench for serial_tx at (8,4), (8,1) and (1,4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_tx;

    logic clk;
    int   checks = 0;
    int   errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int inst, input longint c,
                       input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s inst=%0d cyc=%0d got=%0h exp=%0h", name, inst, c, got, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int DW  = (g == 2) ? 1 : 8;
        localparam int CPB = (g == 1) ? 1 : 4;
        localparam int N   = (DW + 2) * CPB;

        logic          rst_i;
        logic [DW-1:0] tx_data;
        logic          tx_valid;
        logic          tx_ready;
        logic          tx_out;
        logic          busy;
        logic          done;
        bit            fin;

        logic [DW-1:0] q_data[$];
        longint        q_acc[$];
        longint        cyc;
        longint        free_at;

        serial_tx #(
            .DATA_W       (DW),
            .CLKS_PER_BIT (CPB)
        ) u_dut (
            .clk      (clk),
            .rst      (rst_i),
            .tx_data  (tx_data),
            .tx_valid (tx_valid),
            .tx_ready (tx_ready),
            .tx_out   (tx_out),
            .busy     (busy),
            .done     (done)
        );

        // Reference model: a word is taken whenever valid is seen at an edge
        // with reset released and the previous frame plus its done cycle over.
        initial begin
            cyc     = 0;
            free_at = 0;
            forever begin
                @(posedge clk);
                cyc++;
                if (!rst_i) begin
                    q_data.delete();
                    q_acc.delete();
                    free_at = 0;
                end else if (tx_valid && cyc >= free_at) begin
                    q_data.push_back(tx_data);
                    q_acc.push_back(cyc);
                    free_at = cyc + N + 1;
                end
            end
        end

        // Monitor: line bit j cycles after accept is frame[j/CPB], where
        // frame = start(0), data LSB first, stop(1); done lands at j == N.
        initial begin
            longint        j;
            int            bi;
            logic          eb;
            logic [DW-1:0] word;
            word = '0;
            forever begin
                @(negedge clk);
                if (!rst_i || q_acc.size() == 0) begin
                    chk("idle_line",  g, cyc, 32'(tx_out),   32'd1);
                    chk("idle_ready", g, cyc, 32'(tx_ready), 32'd1);
                    chk("idle_busy",  g, cyc, 32'(busy),     32'd0);
                    chk("idle_done",  g, cyc, 32'(done),     32'd0);
                end else begin
                    j = cyc - q_acc[0];
                    if (j < N) begin
                        bi = int'(j / CPB);
                        if (bi == 0)       eb = 1'b0;
                        else if (bi <= DW) eb = q_data[0][bi-1];
                        else               eb = 1'b1;
                        chk("frame_line",  g, cyc, 32'(tx_out),   32'(eb));
                        chk("frame_busy",  g, cyc, 32'(busy),     32'd1);
                        chk("frame_ready", g, cyc, 32'(tx_ready), 32'd0);
                        chk("frame_done",  g, cyc, 32'(done),     32'd0);
                        if (bi >= 1 && bi <= DW && (j % CPB) == CPB / 2)
                            word[bi-1] = tx_out;
                    end else begin
                        chk("done_pulse", g, cyc, 32'(done),     32'd1);
                        chk("done_line",  g, cyc, 32'(tx_out),   32'd1);
                        chk("done_ready", g, cyc, 32'(tx_ready), 32'd1);
                        chk("done_busy",  g, cyc, 32'(busy),     32'd0);
                        chk("frame_word", g, cyc, 32'(word),     32'(q_data[0]));
                        void'(q_data.pop_front());
                        void'(q_acc.pop_front());
                        word = '0;
                    end
                end
            end
        end

        // Stimulus
        initial begin
            fin      = 1'b0;
            rst_i    = 1'b0;
            tx_valid = (g == 2);
            tx_data  = (g == 2) ? DW'(1) : '0;
            repeat (3) @(posedge clk);
            #1 rst_i = 1'b1;

            if (g == 0) begin
                // Abort a frame in its start bit.
                @(posedge clk); #1 tx_valid = 1'b1; tx_data = DW'(8'hA5);
                @(posedge clk); #1 tx_valid = 1'b0;
                @(negedge clk); #2 rst_i = 1'b0;
                #1;
                chk("rst_line",  g, cyc, 32'(tx_out),   32'd1);
                chk("rst_ready", g, cyc, 32'(tx_ready), 32'd1);
                chk("rst_busy",  g, cyc, 32'(busy),     32'd0);
                chk("rst_done",  g, cyc, 32'(done),     32'd0);
                repeat (2) @(posedge clk);
                #1 rst_i = 1'b1;
                // Single frame, then valid/data churn while busy.
                @(posedge clk); #1 tx_valid = 1'b1; tx_data = DW'(8'hA5);
                @(posedge clk); #1 tx_valid = 1'b0;
                repeat (10) @(posedge clk);
                #1 tx_valid = 1'b1; tx_data = DW'(8'hFF);
                repeat (5) @(posedge clk);
                #1 tx_valid = 1'b0;
                repeat (50) @(posedge clk);
                // Back-to-back with valid held high.
                #1 tx_valid = 1'b1; tx_data = DW'(8'h00);
                @(posedge clk); #1 tx_data = DW'(8'hFF);
                repeat (45) @(posedge clk);
                #1 tx_valid = 1'b0;
                repeat (50) @(posedge clk);
            end else if (g == 1) begin
                @(posedge clk); #1 tx_valid = 1'b1; tx_data = DW'(8'h3C);
                @(posedge clk); #1 tx_valid = 1'b0;
                repeat (15) @(posedge clk);
            end else begin
                // Valid was held through reset release.
                @(posedge clk); #1 tx_valid = 1'b0;
                repeat (20) @(posedge clk);
            end

            repeat (25) begin
                case ($urandom_range(0, 2))
                    0: begin
                        #1 tx_valid = 1'b0;
                        repeat ($urandom_range(1, 30)) @(posedge clk);
                    end
                    1: begin
                        #1 tx_valid = 1'b1; tx_data = DW'($urandom);
                        @(posedge clk);
                        #1 tx_valid = 1'b0;
                    end
                    default: begin
                        repeat ($urandom_range(1, 120)) begin
                            #1 tx_valid = 1'b1; tx_data = DW'($urandom);
                            @(posedge clk);
                        end
                        #1 tx_valid = 1'b0;
                    end
                endcase
                #1;
            end
            tx_valid = 1'b0;
            repeat (N + 5) @(posedge clk);
            fin = 1'b1;
        end
    end

    initial begin
        int waited;
        waited = 0;
        while (!(g_inst[0].fin && g_inst[1].fin && g_inst[2].fin) && waited < 60000) begin
            @(posedge clk);
            waited++;
        end
        if (!(g_inst[0].fin && g_inst[1].fin && g_inst[2].fin)) begin
            checks++;
            errors++;
            $display("FAIL timeout got=%0d cycles exp=completion", waited);
        end
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
